// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the pipe_reg_chain retiming pipeline.
// Optional build macro: PIPE_OCCUPANCY_EN (adds the occupancy counter port).
package pipe_reg_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 4;

    // Counter width able to hold 0..stages, never narrower than one bit.
    function automatic int occ_width(input int stages);
        int w;
        w = $clog2(stages + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data+valid register slot of the pipe_reg_chain pipeline.
// Readiness is combinational: the slot accepts when empty or when it is draining.
module pipe_stage
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            // Data only moves with a real item, so bubbles never overwrite it.
            if (in_valid) begin
                data_d = in_data;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// WIDTH-bit, STAGES-deep register pipeline with valid/ready flow control,
// bubble collapsing and synchronous flush. Optional macro: PIPE_OCCUPANCY_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, ready may depend combinationally on the
// downstream ready, and an offered item is held stable until it transfers.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               d_in,
    input  logic                           d_valid,
    output logic                           d_ready,
    output logic [WIDTH-1:0]               q_out,
    output logic                           q_valid,
    input  logic                           q_ready
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(STAGES)-1:0]   occupancy
`endif
);

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             s_rdy;
        logic             s_valid;
        logic [WIDTH-1:0] s_data;
        logic             prv_valid;
        logic [WIDTH-1:0] prv_data;
        logic             nxt_rdy;

        if (i == 0) begin : g_head
            assign prv_valid = d_valid;
            assign prv_data  = d_in;
        end else begin : g_link
            assign prv_valid = g_stage[i-1].s_valid;
            assign prv_data  = g_stage[i-1].s_data;
        end

        // Ready ripples from the consumer back toward the producer.
        if (i == STAGES - 1) begin : g_tail
            assign nxt_rdy = q_ready;
        end else begin : g_mid
            assign nxt_rdy = g_stage[i+1].s_rdy;
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .in_valid (prv_valid),
            .in_data  (prv_data),
            .out_ready(nxt_rdy),
            .in_ready (s_rdy),
            .out_valid(s_valid),
            .out_data (s_data)
        );
    end

    assign d_ready = g_stage[0].s_rdy;
    assign q_valid = g_stage[STAGES-1].s_valid;
    assign q_out   = g_stage[STAGES-1].s_data;

`ifdef PIPE_OCCUPANCY_EN
    localparam int OCC_W = occ_width(STAGES);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = d_valid && d_ready;
    assign out_xfer = q_valid && q_ready;

    // Tracks the popcount of the valid bits without summing them each cycle.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and randomized bench for pipe_reg_chain (STAGES=4 and STAGES=1 instances).
// Covers the occupancy port as well when PIPE_OCCUPANCY_EN is defined.
module tb_pipe_reg_chain;
    import pipe_reg_pkg::*;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         flush    = 1'b0;
    logic [W-1:0] d_in     = '0;
    logic         d_valid  = 1'b0;
    logic         q_ready  = 1'b0;
    logic         d_ready;
    logic         q_valid;
    logic [W-1:0] q_out;
    logic [W-1:0] d1_in    = '0;
    logic         d1_valid = 1'b0;
    logic         q1_ready = 1'b0;
    logic         d1_ready;
    logic         q1_valid;
    logic [W-1:0] q1_out;
`ifdef PIPE_OCCUPANCY_EN
    logic [occ_width(S)-1:0] occupancy;
    logic [occ_width(1)-1:0] occupancy1;
`endif

    int           n_cmp  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    bit           chk_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp1_q[$];
    int           pop_cyc_q[$];
    int           acc_cyc_q[$];

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .d_in     (d_in),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .q_out    (q_out),
        .q_valid  (q_valid),
        .q_ready  (q_ready)
`ifdef PIPE_OCCUPANCY_EN
        ,
        .occupancy(occupancy)
`endif
    );

    pipe_reg_chain #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .d_in     (d1_in),
        .d_valid  (d1_valid),
        .d_ready  (d1_ready),
        .q_out    (q1_out),
        .q_valid  (q1_valid),
        .q_ready  (q1_ready)
`ifdef PIPE_OCCUPANCY_EN
        ,
        .occupancy(occupancy1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for outputs to settle mid-cycle; checks follow this call.
    task automatic settle();
        @(negedge clk);
    endtask

    // Score the transfers happening on the coming edge, then advance past it.
    task automatic tick();
        if (chk_en) begin
`ifdef PIPE_OCCUPANCY_EN
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("occupancy1", 32'(occupancy1), 32'(exp1_q.size()));
`endif
        end
        if (reset) begin
            exp_q.delete();
            exp1_q.delete();
        end else begin
            if (q_valid && q_ready) begin
                pop_cyc_q.push_back(cyc);
                check("out_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) check("q_out", 32'(q_out), 32'(exp_q.pop_front()));
            end
            if (flush) exp_q.delete();
            else if (d_valid && d_ready) begin
                exp_q.push_back(d_in);
                acc_cyc_q.push_back(cyc);
            end
            if (q1_valid && q1_ready) begin
                check("out1_expected", 32'(exp1_q.size() != 0), 32'(1));
                if (exp1_q.size() != 0) check("q1_out", 32'(q1_out), 32'(exp1_q.pop_front()));
            end
            if (flush) exp1_q.delete();
            else if (d1_valid && d1_ready) exp1_q.push_back(d1_in);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        q_ready  = 1'b1;
        q1_ready = 1'b1;
        d_valid  = 1'b0;
        d1_valid = 1'b0;
        flush    = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        check("drain1_empty", 32'(exp1_q.size()), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        reset = 1'b1;
        repeat (2) step();
        reset  = 1'b0;
        chk_en = 1'b1;
        settle();
        check("rst_q_valid", 32'(q_valid), 32'(0));
        check("rst_q_out", 32'(q_out), 32'(0));
        check("rst_d_ready", 32'(d_ready), 32'(1));
        check("rst_q1_valid", 32'(q1_valid), 32'(0));
        check("rst_d1_ready", 32'(d1_ready), 32'(1));
`ifdef PIPE_OCCUPANCY_EN
        check("rst_occupancy", 32'(occupancy), 32'(0));
`endif
        tick();

        // Stream 0x01..0x08 with the consumer always ready
        q_ready = 1'b1;
        pop_cyc_q.delete();
        acc_cyc_q.delete();
        for (int i = 1; i <= 8; i++) begin
            d_valid = 1'b1;
            d_in    = W'(i);
            settle();
            check("stream_d_ready", 32'(d_ready), 32'(1));
            tick();
        end
        drain(20);
        check("stream_count", 32'(pop_cyc_q.size()), 32'(8));
        if (pop_cyc_q.size() == 8 && acc_cyc_q.size() == 8) begin
            check("stream_latency", 32'(pop_cyc_q[0] - acc_cyc_q[0]), 32'(S));
            for (int i = 1; i < 8; i++)
                check("stream_gap", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'(1));
        end

        // Fill under stall: exactly S accepted
        q_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d_valid = 1'b1;
            d_in    = W'(8'hA0 + i);
            settle();
            check("fill_d_ready", 32'(d_ready), 32'(i < S));
            tick();
        end
        d_valid = 1'b0;
        settle();
        check("full_d_ready", 32'(d_ready), 32'(0));
        check("full_q_valid", 32'(q_valid), 32'(1));
        check("full_head", 32'(q_out), 32'(8'hA0));
        check("full_count", 32'(exp_q.size()), 32'(S));
        tick();
        drain(20);

        // Bubble collapse under stall
        q_ready = 1'b0;
        d_valid = 1'b1;
        d_in    = 8'h11;
        settle();
        check("bub_d_ready", 32'(d_ready), 32'(1));
        tick();
        d_valid = 1'b0;
        repeat (2) begin
            settle();
            check("bub_idle_d_ready", 32'(d_ready), 32'(1));
            tick();
        end
        d_valid = 1'b1;
        d_in    = 8'h22;
        settle();
        check("bub_d_ready2", 32'(d_ready), 32'(1));
        tick();
        d_valid = 1'b0;
        repeat (3) begin
            settle();
            check("bub_hold_d_ready", 32'(d_ready), 32'(1));
            tick();
        end
        q_ready = 1'b1;
        settle();
        check("bub_head_valid", 32'(q_valid), 32'(1));
        check("bub_head_data", 32'(q_out), 32'(8'h11));
        tick();
        settle();
        check("bub_adjacent_valid", 32'(q_valid), 32'(1));
        check("bub_adjacent_data", 32'(q_out), 32'(8'h22));
        tick();
        settle();
        check("bub_empty", 32'(q_valid), 32'(0));
        tick();

        // Flush with concurrent input and output transfer
        q_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            d_valid = 1'b1;
            d_in    = W'(8'hB0 + i);
            step();
        end
        d_valid = 1'b0;
        repeat (2) step();
        q_ready = 1'b1;
        flush   = 1'b1;
        d_valid = 1'b1;
        d_in    = 8'h55;
        settle();
        check("flush_head_valid", 32'(q_valid), 32'(1));
        check("flush_head_data", 32'(q_out), 32'(8'hB1));
        tick();
        flush   = 1'b0;
        d_valid = 1'b0;
        settle();
        check("flush_q_valid", 32'(q_valid), 32'(0));
        check("flush_d_ready", 32'(d_ready), 32'(1));
`ifdef PIPE_OCCUPANCY_EN
        check("flush_occupancy", 32'(occupancy), 32'(0));
`endif
        tick();
        repeat (6) step();

        // Mid-stream reset
        q_ready = 1'b1;
        d_valid = 1'b1;
        d_in    = 8'hC1;
        step();
        d_in    = 8'hC2;
        step();
        d_valid = 1'b0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        settle();
        check("mrst_q_valid", 32'(q_valid), 32'(0));
        check("mrst_q_out", 32'(q_out), 32'(0));
        check("mrst_d_ready", 32'(d_ready), 32'(1));
`ifdef PIPE_OCCUPANCY_EN
        check("mrst_occupancy", 32'(occupancy), 32'(0));
`endif
        tick();
        repeat (5) step();

        // Full chain with simultaneous input and output transfers
        q_ready = 1'b0;
        for (int i = 0; i < S; i++) begin
            d_valid = 1'b1;
            d_in    = W'(8'hD0 + i);
            step();
        end
        q_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_valid = 1'b1;
            d_in    = W'(8'hE0 + i);
            settle();
            check("thru_d_ready", 32'(d_ready), 32'(1));
            check("thru_count", 32'(exp_q.size()), 32'(S));
            tick();
        end
        drain(20);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            d_valid = 1'($urandom_range(0, 1));
            d_in    = W'($urandom_range(0, 255));
            q_ready = 1'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 15) == 0);
            step();
        end
        drain(40);

        // STAGES = 1: alternating consumer readiness, continuous producer
        d1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            q1_ready = (i % 2 == 0);
            d1_in    = W'(8'h30 + i);
            settle();
            check("s1_q_valid", 32'(q1_valid), 32'(exp1_q.size() != 0));
            check("s1_d_ready", 32'(d1_ready), 32'(exp1_q.size() == 0 || q1_ready));
            tick();
        end
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, STAGES-deep register pipeline with valid/ready flow control, bubble collapsing, and a synchronous flush. It sits between producer and consumer blocks that need fixed register retiming with backpressure. It replaces ad-hoc chains of single-bit flops in datapaths.

## Interface
- WIDTH, 8, data width in bits (≥1)
- STAGES, 4, number of register stages (≥1)

- clk  input  1  rising-edge clock; all state updates on posedge clk
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of all stage valid bits
- d_in  input  WIDTH  input data
- d_valid  input  1  d_in is valid
- d_ready  output  1  chain can accept d_in this cycle
- q_out  output  WIDTH  data of last stage (registered)
- q_valid  output  1  valid bit of last stage (registered)
- q_ready  input  1  consumer accepts q_out this cycle
- occupancy  output  $clog2(STAGES+1)  number of valid stages; present only with PIPE_OCCUPANCY_EN

## Operation
- Each stage i (0 = input side, STAGES-1 = output side) holds data[i] and valid[i].
- Stage readiness: rdy[STAGES-1] = !valid[STAGES-1] || q_ready; rdy[i] = !valid[i] || rdy[i+1]. d_ready = rdy[0]. The ready path is combinational through the chain.
- Stage 0 loads d_in and sets valid[0] = d_valid when rdy[0].
- Stage i>0 loads data[i-1] and valid[i-1] when rdy[i].
- A stage that is not ready holds data and valid.
- Data registers load only when their stage advances. Otherwise they hold, so bubbles do not clobber data.
- Bubble collapsing: with the output stalled, upstream stages keep filling until all valid bits are set. Only then does d_ready drop.
- Output transfer occurs when q_valid && q_ready. Input transfer occurs when d_valid && d_ready.
- Flush: all valid[i] are 0 after the edge. The data registers are not cleared.
  - An input transfer in the flush cycle is dropped.
  - An output transfer in the flush cycle completes normally, because the consumer already sampled it.
- Reset overrides flush and all other inputs. After the reset edge, every valid bit and every data register is 0.
- Ordering is strictly FIFO. No item is duplicated or lost except by flush.

## Timing
- Reset values: q_out = 0, q_valid = 0, occupancy = 0. d_ready = 1 from the first cycle after reset.
- Latency with no stall: an item accepted at edge N appears with q_valid = 1 after edge N+STAGES-1, i.e. STAGES edges including the accept edge.
- Throughput is 1 item/cycle when q_ready is held at 1.
- With STAGES = 1 the block is a single skid-less register: d_ready = !q_valid || q_ready.
- Full: all STAGES valid and q_ready = 0 → d_ready = 0. Capacity is exactly STAGES items.
- Simultaneous input and output transfer on a full chain is allowed. Occupancy is unchanged.
- Reset mid-stream discards all contents. No output transfer is reported on the reset cycle's edge.

## Configuration
- PIPE_OCCUPANCY_EN defined: the occupancy port exists as a registered counter.
  - Input transfer without flush adds 1.
  - Output transfer subtracts 1.
  - Both in the same cycle leave it unchanged.
  - Flush sets it to 0.
  - Reset sets it to 0.
  - It must always equal the popcount of the valid bits.
- PIPE_OCCUPANCY_EN undefined: no occupancy port and no counter logic. All other behaviour is identical.

## Structure
- Package pipe_reg_pkg holds:
  - an occupancy-width helper function returning $clog2(STAGES+1) with a minimum of 1;
  - the default WIDTH and STAGES constants.
- Sub-module pipe_stage holds one data+valid register. Its inputs are clk, reset, flush, in_valid, in_data and out_ready; its outputs are in_ready, out_valid and out_data.
- The top level generates STAGES instances and chains the ready signals.

## Test plan
- Reset then stream: WIDTH = 8, STAGES = 4, q_ready = 1, inputs 0x01..0x08 on consecutive cycles → q_out shows 0x01..0x08 in order, first q_valid 4 edges after the first accept, no gaps.
- Fill under stall: q_ready = 0, push 0xA0..0xA5 → exactly 4 accepted (0xA0..0xA3), d_ready = 0 afterwards, occupancy = 4. Then release q_ready → 0xA0..0xA3 emerge in order.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22 with q_ready = 0 → both items sit in the last two stages adjacently, and d_ready stays 1 while any stage is empty.
- Flush with concurrent I/O: chain holds 3 items, q_ready = 1, flush = 1, d_valid = 1 with 0x55 → the head item is transferred, then q_valid = 0, occupancy = 0, and 0x55 never appears.
- Mid-stream reset: 2 items in flight, assert reset for 1 cycle → q_valid = 0, q_out = 0, occupancy = 0, d_ready = 1 after the edge.
- STAGES = 1 build: alternate q_ready 1/0 with continuous d_valid → one item per accepting cycle, d_ready tracks !q_valid || q_ready.
